// File: rtl/led_shift_sequencer.sv
// led_shift_sequencer: prescaled LED pattern shifter driven by a valid/ready command port.
// Commands: LOAD, SET_PERIOD, SET_MODE, STEP. Modes: STOP, ROT_R, ROT_L, BOUNCE.
// Optional feature macro LED_PWM_EN: adds a brightness register and a free-running PWM
// counter that gate the LED drive. The parameter PWM_W exists only in that build.
module led_shift_sequencer #(
  parameter int unsigned LEDS_NR       = 24,
  parameter int unsigned PRESC_W       = 23,
  parameter int unsigned PRESC_DEFAULT = 6_000_000
`ifdef LED_PWM_EN
  ,
  parameter int unsigned PWM_W         = 4
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEDS_NR-1:0] cmd_data,
  output logic               tick,
  output logic [LEDS_NR-1:0] pattern,
  output logic [LEDS_NR-1:0] led
);

  typedef enum logic [1:0] {
    OP_LOAD       = 2'd0,
    OP_SET_PERIOD = 2'd1,
    OP_SET_MODE   = 2'd2,
    OP_STEP       = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    MODE_STOP   = 2'd0,
    MODE_ROT_R  = 2'd1,
    MODE_ROT_L  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_t;

  logic               reset_q;
  logic [PRESC_W-1:0] period;
  logic [PRESC_W-1:0] cnt;
  mode_t              mode;
  dir_t               dir;
  op_t                op;
  logic               accept;
  logic [LEDS_NR-1:0] rot_r;
  logic [LEDS_NR-1:0] rot_l;
  logic [LEDS_NR-1:0] shr;
  logic [LEDS_NR-1:0] shl;
  logic [LEDS_NR-1:0] step_pattern;
  dir_t               step_dir;

  // Tick decodes the prescaler; commands are refused in tick cycles so they never collide.
  assign tick      = (cnt == '0);
  assign cmd_ready = ~reset_q & ~tick;
  assign accept    = cmd_valid & cmd_ready;
  assign op        = op_t'(cmd_op);

  assign rot_r = {pattern[0], pattern[LEDS_NR-1:1]};
  assign rot_l = {pattern[LEDS_NR-2:0], pattern[LEDS_NR-1]};
  assign shr   = {1'b0, pattern[LEDS_NR-1:1]};
  assign shl   = {pattern[LEDS_NR-2:0], 1'b0};

  // One shift of the current mode; STOP uses dir as a rotate (only reachable via STEP).
  always_comb begin
    step_pattern = pattern;
    step_dir     = dir;
    case (mode)
      MODE_STOP:  step_pattern = (dir == DIR_RIGHT) ? rot_r : rot_l;
      MODE_ROT_R: step_pattern = rot_r;
      MODE_ROT_L: step_pattern = rot_l;
      MODE_BOUNCE: begin
        if (dir == DIR_RIGHT) begin
          if (pattern[0]) begin
            step_dir     = DIR_LEFT;
            step_pattern = shl;
          end else begin
            step_pattern = shr;
          end
        end else begin
          if (pattern[LEDS_NR-1]) begin
            step_dir     = DIR_RIGHT;
            step_pattern = shr;
          end else begin
            step_pattern = shl;
          end
        end
      end
    endcase
  end

  // Delayed reset keeps cmd_ready low for the first cycle after reset is released.
  always_ff @(posedge clk) begin
    reset_q <= reset;
  end

  // Prescaler: count down to zero, reload from period; SET_PERIOD restarts the interval.
  always_ff @(posedge clk) begin
    if (reset) begin
      period <= PRESC_W'(PRESC_DEFAULT);
      cnt    <= PRESC_W'(PRESC_DEFAULT);
    end else if (accept && (op == OP_SET_PERIOD)) begin
      period <= cmd_data[PRESC_W-1:0];
      cnt    <= cmd_data[PRESC_W-1:0];
    end else if (tick) begin
      cnt <= period;
    end else begin
      cnt <= cnt - PRESC_W'(1);
    end
  end

  // Pattern, mode and direction: tick-driven shifts and accepted commands never coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern <= LEDS_NR'(1);
      mode    <= MODE_ROT_R;
      dir     <= DIR_RIGHT;
    end else if (tick) begin
      if (mode != MODE_STOP) begin
        pattern <= step_pattern;
        dir     <= step_dir;
      end
    end else if (accept) begin
      case (op)
        OP_LOAD:       pattern <= cmd_data;
        OP_SET_PERIOD: ;
        OP_SET_MODE: begin
          mode <= mode_t'(cmd_data[1:0]);
          if (mode_t'(cmd_data[1:0]) == MODE_ROT_R) dir <= DIR_RIGHT;
          if (mode_t'(cmd_data[1:0]) == MODE_ROT_L) dir <= DIR_LEFT;
        end
        OP_STEP: begin
          pattern <= step_pattern;
          dir     <= step_dir;
        end
      endcase
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] brightness;
  logic [PWM_W-1:0] pwm_cnt;

  // Brightness comes with SET_MODE; pwm_cnt free-runs and gates lit LEDs.
  always_ff @(posedge clk) begin
    if (reset) begin
      brightness <= '1;
      pwm_cnt    <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      if (accept && (op == OP_SET_MODE)) brightness <= cmd_data[PWM_W+3:4];
    end
  end

  assign led = ~(pattern & {LEDS_NR{pwm_cnt <= brightness}});
`else
  assign led = ~pattern;
`endif

endmodule

// File: tb/tb_led_shift_sequencer.sv
// tb_led_shift_sequencer: directed scenarios plus randomized commands against a reference model.
module tb_led_shift_sequencer;

  localparam int unsigned N     = 24;
  localparam int unsigned DEF   = 6_000_000;
  localparam int unsigned TOP   = 32'h0080_0000;
  localparam int unsigned FULL  = 32'h0100_0000;
  localparam int unsigned PMOD  = 32'h0080_0000;

  logic         clk       = 1'b0;
  logic         reset     = 1'b1;
  logic         cmd_valid = 1'b0;
  logic [1:0]   cmd_op    = 2'd0;
  logic [N-1:0] cmd_data  = '0;
  logic         cmd_ready;
  logic         tick;
  logic [N-1:0] pattern;
  logic [N-1:0] led;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase counts cycles since the last interval start; left=1 means LEFT.
  logic [N-1:0] m_pattern = N'(1);
  int unsigned  m_period  = DEF;
  int unsigned  m_phase   = 0;
  int           m_mode    = 1;
  bit           m_left    = 1'b0;
  bit           m_rq      = 1'b1;
`ifdef LED_PWM_EN
  logic [3:0]   m_bright  = 4'hF;
  logic [3:0]   m_pwm     = 4'h0;
`endif

  led_shift_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .tick      (tick),
    .pattern   (pattern),
    .led       (led)
  );

  always #5 clk = ~clk;

  function automatic logic [N:0] shift_ref(input logic [N-1:0] p, input int mode, input bit left);
    int unsigned v, nv, rr, rl;
    bit nl;
    v  = 32'(p);
    nl = left;
    rr = v / 2 + (v % 2) * TOP;
    rl = (v * 2) % FULL + v / TOP;
    case (mode)
      0:       nv = left ? rl : rr;
      1:       nv = rr;
      2:       nv = rl;
      default: begin
        if (!left) begin
          if (v % 2 == 1) begin nl = 1'b1; nv = (v * 2) % FULL; end
          else nv = v / 2;
        end else begin
          if (v / TOP == 1) begin nl = 1'b0; nv = v / 2; end
          else nv = (v * 2) % FULL;
        end
      end
    endcase
    return {nl, N'(nv)};
  endfunction

  function automatic bit exp_tick();
    return m_phase == m_period;
  endfunction

  function automatic bit exp_ready();
    return !m_rq && !exp_tick();
  endfunction

  function automatic logic [N-1:0] exp_led();
`ifdef LED_PWM_EN
    return ~(m_pattern & {N{m_pwm <= m_bright}});
`else
    return ~m_pattern;
`endif
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void model_edge();
    bit t, acc;
    logic [N:0] s;
    t   = exp_tick();
    acc = cmd_valid && exp_ready();
    if (reset) begin
      m_rq = 1'b1; m_pattern = N'(1); m_period = DEF; m_phase = 0; m_mode = 1; m_left = 1'b0;
`ifdef LED_PWM_EN
      m_bright = 4'hF; m_pwm = 4'h0;
`endif
    end else begin
      m_rq = 1'b0;
`ifdef LED_PWM_EN
      m_pwm = m_pwm + 4'd1;
`endif
      if (t) begin
        m_phase = 0;
        if (m_mode != 0) begin
          s = shift_ref(m_pattern, m_mode, m_left);
          m_pattern = s[N-1:0]; m_left = s[N];
        end
      end else begin
        m_phase = m_phase + 1;
      end
      if (acc) begin
        case (cmd_op)
          2'd0: m_pattern = cmd_data;
          2'd1: begin m_period = 32'(cmd_data) % PMOD; m_phase = 0; end
          2'd2: begin
            m_mode = int'(cmd_data[1:0]);
            if (m_mode == 1) m_left = 1'b0;
            if (m_mode == 2) m_left = 1'b1;
`ifdef LED_PWM_EN
            m_bright = cmd_data[7:4];
`endif
          end
          default: begin
            s = shift_ref(m_pattern, m_mode, m_left);
            m_pattern = s[N-1:0]; m_left = s[N];
          end
        endcase
      end
    end
  endfunction

  task automatic tick_clk();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick_clk();
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [N-1:0] data, output bit ok);
    bit acc;
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    for (int i = 0; i < 20 && !ok; i++) begin
      acc = exp_ready();
      tick_clk();
      ok = acc;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0; reset = 1'b1;
    idle(2);
    reset = 1'b0;
    tick_clk();
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0;
    idle(3);
    n_checks++; if (pattern !== 24'h000001) begin n_fail++; $display("FAIL reset_pattern got %h want %h", pattern, 24'h000001); end
    n_checks++; if (led !== 24'hFFFFFE) begin n_fail++; $display("FAIL reset_led got %h want %h", led, 24'hFFFFFE); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", cmd_ready); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b want 0", tick); end
    reset = 1'b0;
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL release_ready_low got %b want 0", cmd_ready); end
    tick_clk();
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready_high got %b want 1", cmd_ready); end
  endtask

  task automatic test_rotate();
    bit ok1, ok2, ok3;
    do_reset();
    send_cmd(2'd2, N'(1), ok1);
    send_cmd(2'd1, N'(0), ok2);
    n_checks++; if ({ok1, ok2} !== 2'b11) begin n_fail++; $display("FAIL rotr_cmds accepted %b want 11", {ok1, ok2}); end
    n_checks++; if ({tick, cmd_ready} !== 2'b10) begin n_fail++; $display("FAIL period0_tick_ready got %b want 10", {tick, cmd_ready}); end
    tick_clk();
    n_checks++; if (pattern !== 24'h800000) begin n_fail++; $display("FAIL rotr_step1 got %h want %h", pattern, 24'h800000); end
    tick_clk();
    n_checks++; if (pattern !== 24'h400000 || pattern !== m_pattern) begin n_fail++; $display("FAIL rotr_step2 got %h want %h", pattern, 24'h400000); end
    do_reset();
    send_cmd(2'd0, 24'h800000, ok1);
    send_cmd(2'd2, N'(2), ok2);
    send_cmd(2'd1, N'(0), ok3);
    n_checks++; if ({ok1, ok2, ok3} !== 3'b111) begin n_fail++; $display("FAIL rotl_cmds accepted %b want 111", {ok1, ok2, ok3}); end
    tick_clk();
    n_checks++; if (pattern !== 24'h000001) begin n_fail++; $display("FAIL rotl_wrap got %h want %h", pattern, 24'h000001); end
  endtask

  task automatic test_handshake();
    bit ok;
    int ticks;
    int waited;
    logic [N-1:0] val;
    do_reset();
    send_cmd(2'd1, N'(3), ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL hs_set_period accepted %b want 1", ok); end
    ticks = 0;
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (tick !== exp_tick()) begin n_fail++; $display("FAIL hs_tick cyc %0d got %b want %b", i, tick, exp_tick()); end
      n_checks++; if (cmd_ready !== exp_ready()) begin n_fail++; $display("FAIL hs_ready cyc %0d got %b want %b", i, cmd_ready, exp_ready()); end
      if (tick === 1'b1) ticks++;
      tick_clk();
    end
    n_checks++; if (ticks != 4) begin n_fail++; $display("FAIL hs_tick_count got %0d want 4", ticks); end
    waited = 0;
    while (!exp_tick() && waited < 8) begin tick_clk(); waited++; end
    n_checks++; if (waited >= 8) begin n_fail++; $display("FAIL hs_align waited %0d cycles want <8", waited); end
    val = N'($urandom);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = val;
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL hs_ready_in_tick got %b want 0", cmd_ready); end
    tick_clk();
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL hs_ready_after_tick got %b want 1", cmd_ready); end
    tick_clk();
    cmd_valid = 1'b0;
    n_checks++; if (pattern !== val) begin n_fail++; $display("FAIL hs_held_load got %h want %h", pattern, val); end
  endtask

  task automatic test_bounce();
    bit ok1, ok2, ok3;
    logic [N-1:0] seq [4];
    seq[0] = 24'h000002; seq[1] = 24'h000001; seq[2] = 24'h000002; seq[3] = 24'h000004;
    do_reset();
    send_cmd(2'd0, 24'h000002, ok1);
    send_cmd(2'd2, N'(3), ok2);
    send_cmd(2'd1, N'(0), ok3);
    n_checks++; if ({ok1, ok2, ok3} !== 3'b111) begin n_fail++; $display("FAIL bounce_cmds accepted %b want 111", {ok1, ok2, ok3}); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (pattern !== seq[i] || pattern !== m_pattern) begin n_fail++; $display("FAIL bounce_seq %0d got %h want %h", i, pattern, seq[i]); end
      tick_clk();
    end
  endtask

  task automatic test_stop_step();
    bit ok;
    bit all_ok;
    all_ok = 1'b1;
    do_reset();
    send_cmd(2'd2, N'(2), ok); all_ok &= ok;
    send_cmd(2'd2, N'(0), ok); all_ok &= ok;
    send_cmd(2'd0, N'(1), ok); all_ok &= ok;
    send_cmd(2'd3, N'(0), ok); all_ok &= ok;
    n_checks++; if (pattern !== 24'h000002) begin n_fail++; $display("FAIL stop_step_left got %h want %h", pattern, 24'h000002); end
    send_cmd(2'd1, N'(1), ok); all_ok &= ok;
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (pattern !== 24'h000002) begin n_fail++; $display("FAIL stop_hold cyc %0d got %h want %h", i, pattern, 24'h000002); end
      tick_clk();
    end
    send_cmd(2'd0, N'(0), ok); all_ok &= ok;
    for (int m = 0; m < 4; m++) begin
      send_cmd(2'd2, N'(m), ok); all_ok &= ok;
      idle(4);
      send_cmd(2'd3, N'(0), ok); all_ok &= ok;
      n_checks++; if (pattern !== '0) begin n_fail++; $display("FAIL zero_stays mode %0d got %h want 000000", m, pattern); end
    end
    n_checks++; if (all_ok !== 1'b1) begin n_fail++; $display("FAIL stop_cmds accepted %b want 1", all_ok); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int ticks;
    do_reset();
    send_cmd(2'd2, N'(3), ok);
    send_cmd(2'd0, N'($urandom), ok);
    send_cmd(2'd1, N'(2), ok);
    idle(5);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 24'hA5A5A5;
    reset = 1'b1;
    tick_clk();
    cmd_valid = 1'b0;
    n_checks++; if (pattern !== 24'h000001) begin n_fail++; $display("FAIL mid_reset_pattern got %h want %h", pattern, 24'h000001); end
    n_checks++; if ({tick, cmd_ready} !== 2'b00) begin n_fail++; $display("FAIL mid_reset_tick_ready got %b want 00", {tick, cmd_ready}); end
    n_checks++; if (led !== 24'hFFFFFE) begin n_fail++; $display("FAIL mid_reset_led got %h want %h", led, 24'hFFFFFE); end
    reset = 1'b0;
    tick_clk();
    n_checks++; if (pattern !== 24'h000001) begin n_fail++; $display("FAIL mid_reset_cmd_dropped got %h want %h", pattern, 24'h000001); end
    send_cmd(2'd3, N'(0), ok);
    n_checks++; if (pattern !== 24'h800000 || ok !== 1'b1) begin n_fail++; $display("FAIL mid_reset_mode_rotr got %h want %h", pattern, 24'h800000); end
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      if (tick === 1'b1) ticks++;
      tick_clk();
    end
    n_checks++; if (ticks != 0) begin n_fail++; $display("FAIL mid_reset_period_default ticks %0d want 0", ticks); end
  endtask

  task automatic test_random();
    bit ok;
    logic [N-1:0] d;
    do_reset();
    send_cmd(2'd1, N'($urandom_range(4, 1)), ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rnd_set_period accepted %b want 1", ok); end
    for (int i = 0; i < 600; i++) begin
      cmd_valid = ($urandom % 2) == 1;
      cmd_op    = 2'($urandom);
      d         = N'($urandom);
      if (cmd_op == 2'd1) d = N'((32'(d) & TOP) | $urandom_range(5, 1));
      cmd_data  = d;
      n_checks++; if (pattern !== m_pattern) begin n_fail++; $display("FAIL rnd_pattern cyc %0d got %h want %h", i, pattern, m_pattern); end
      n_checks++; if (led !== exp_led()) begin n_fail++; $display("FAIL rnd_led cyc %0d got %h want %h", i, led, exp_led()); end
      n_checks++; if (tick !== exp_tick()) begin n_fail++; $display("FAIL rnd_tick cyc %0d got %b want %b", i, tick, exp_tick()); end
      n_checks++; if (cmd_ready !== exp_ready()) begin n_fail++; $display("FAIL rnd_ready cyc %0d got %b want %b", i, cmd_ready, exp_ready()); end
      tick_clk();
    end
    cmd_valid = 1'b0;
  endtask

`ifdef LED_PWM_EN
  task automatic test_pwm();
    bit ok;
    int lit;
    do_reset();
    send_cmd(2'd2, 24'h000031, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL pwm_set_mode accepted %b want 1", ok); end
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      if (led[0] === 1'b0) lit++;
      n_checks++; if (led !== exp_led()) begin n_fail++; $display("FAIL pwm_led cyc %0d got %h want %h", i, led, exp_led()); end
      tick_clk();
    end
    n_checks++; if (lit != 4) begin n_fail++; $display("FAIL pwm_duty lit %0d of 16 want 4", lit); end
  endtask
`endif

  initial begin
    test_reset();
    test_rotate();
    test_handshake();
    test_bounce();
    test_stop_step();
    test_reset_mid();
    test_random();
`ifdef LED_PWM_EN
    test_pwm();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
